// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcodes, flag bit positions, and arbiter states.
package alu_arb_pkg;

    localparam logic [3:0] OP_PASS_B = 4'b0000;
    localparam logic [3:0] OP_ADD    = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_RLC    = 4'b0011;
    localparam logic [3:0] OP_RRC    = 4'b0100;
    localparam logic [3:0] OP_SETC   = 4'b0101;
    localparam logic [3:0] OP_CLRC   = 4'b0110;
    localparam logic [3:0] OP_AND    = 4'b0111;
    localparam logic [3:0] OP_OR     = 4'b1000;
    localparam logic [3:0] OP_XOR    = 4'b1001;
    localparam logic [3:0] OP_PASS_A = 4'b1110;

    // Bit positions inside the {V,C,N,Z} flag nibble
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    typedef enum logic {
        S_FREE,
        S_LOCK
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant plus its index, searching from ptr+1 upward.
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk ptr+1, ptr+2, ... with wrap; the first asserted request wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = IDX_W'((int'(ptr) + k) % int'(NUM_REQ));
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters, with ownership lock and a
// registered one-cycle response. Optional lock hold timeout: ALU_ARB_LOCK_TIMEOUT_EN.
module alu_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned OP_W     = 4,
    parameter int unsigned LOCK_MAX = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ-1:0]       req_lock,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [OP_W-1:0]          alu_op,
    input  logic [DATA_W-1:0]        alu_out,
    input  logic [3:0]               alu_flags,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [3:0]               rsp_flags,
    output logic                     lock_timeout
);
    import alu_arb_pkg::*;

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (LOCK_MAX > 15) begin : g_lock_max_chk
        $error("LOCK_MAX must fit the 4-bit hold counter");
    end

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] pick_grant, grant;
    logic [IDX_W-1:0]   pick_idx, gidx;
    logic               accept;
    logic               timeout_hit;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic [3:0]         rsp_flags_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // While locked only the owner may be granted; otherwise the round-robin pick.
    always_comb begin
        grant = '0;
        gidx  = owner_q;
        if (state_q == S_LOCK) begin
            grant[owner_q] = req_valid[owner_q];
        end else begin
            grant = pick_grant;
            gidx  = pick_idx;
        end
    end

    assign accept    = |grant;
    assign req_ready = grant;

    // Idle drives pass-B of zero so the ALU condition codes are left untouched.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_W'(OP_PASS_B);
        if (accept) begin
            alu_a  = req_a[gidx*DATA_W +: DATA_W];
            alu_b  = req_b[gidx*DATA_W +: DATA_W];
            alu_op = req_op[gidx*OP_W +: OP_W];
        end
    end

`ifdef ALU_ARB_LOCK_TIMEOUT_EN
    logic [3:0] hold_cnt_q;

    // Cycles the owner has left the lock unused; an owner accept wins over a same-cycle expiry.
    always_ff @(posedge clk) begin
        if (rst || state_q != S_LOCK || accept) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
        end
    end

    assign timeout_hit = (state_q == S_LOCK) && !accept && (hold_cnt_q == 4'(LOCK_MAX));
`else
    assign timeout_hit = 1'b0;
`endif

    assign lock_timeout = timeout_hit;

    // Next-state, pointer and owner update.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        case (state_q)
            S_FREE: begin
                if (accept) begin
                    rr_ptr_d = gidx;
                    if (req_lock[gidx] && NUM_REQ > 1) begin
                        state_d = S_LOCK;
                        owner_d = gidx;
                    end
                end
            end
            S_LOCK: begin
                if (accept) begin
                    if (!req_lock[owner_q]) state_d = S_FREE;
                end else if (timeout_hit) begin
                    // Forced release hands the owner lowest priority next round.
                    state_d  = S_FREE;
                    rr_ptr_d = owner_q;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    // FSM state, pointer and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Response registers: pulse follows the accept, data/flags hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            rsp_valid_q <= grant;
            if (accept) begin
                rsp_data_q  <= alu_out;
                rsp_flags_q <= alu_flags;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed test-plan steps followed by random traffic,
// all checked against a transaction-level reference model. Honours ALU_ARB_LOCK_TIMEOUT_EN.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned LOCK_MAX = 15;
`ifdef ALU_ARB_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid, req_ready, req_lock, rsp_valid;
    logic [NUM_REQ*8-1:0] req_a, req_b;
    logic [NUM_REQ*4-1:0] req_op;
    logic [7:0]           alu_a, alu_b, alu_out, rsp_data;
    logic [3:0]           alu_op, alu_flags, rsp_flags;
    logic                 lock_timeout;
    logic [3:0]           ccr = 4'b0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (8),
        .OP_W     (4),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .req_lock     (req_lock),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_out      (alu_out),
        .alu_flags    (alu_flags),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_flags    (rsp_flags),
        .lock_timeout (lock_timeout)
    );

    // ALU behaviour: returns {V,C,N,Z, result}; carry/overflow persist unless the op sets them.
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op, input logic [3:0] cc);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        c = cc[FLAG_C];
        v = cc[FLAG_V];
        r = b;
        case (op)
            OP_ADD: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0];
                c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUB: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[7:0];
                c = w[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            OP_RLC:    begin r = {b[6:0], c}; c = b[7]; end
            OP_RRC:    begin r = {c, b[7:1]}; c = b[0]; end
            OP_SETC:   c = 1'b1;
            OP_CLRC:   c = 1'b0;
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_PASS_A: r = a;
            default:   r = b;
        endcase
        return {v, c, r[7], (r == 8'h00), r};
    endfunction

    // Environment ALU with its condition-code register.
    always_comb {alu_flags, alu_out} = alu_fn(alu_a, alu_b, alu_op, ccr);
    always_ff @(posedge clk) ccr <= rst ? 4'b0 : alu_flags;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           m_locked;
    int           m_owner, m_ptr, m_idle;
    logic [3:0]   m_ccr;
    logic [NUM_REQ-1:0] m_rsp_valid;
    logic [7:0]   m_rsp_data;
    logic [3:0]   m_rsp_flags;

    // Last observed DUT values from the most recent step
    logic [NUM_REQ-1:0] last_ready;
    logic [3:0]         last_op;
    logic               last_to;
    int                 last_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_owner     = 0;
        m_ptr       = NUM_REQ - 1;
        m_idle      = 0;
        m_ccr       = 4'b0;
        m_rsp_valid = '0;
        m_rsp_data  = 8'h00;
        m_rsp_flags = 4'h0;
    endtask

    task automatic set_req(input int i, input bit v, input bit lk, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] op);
        req_valid[i]      = v;
        req_lock[i]       = lk;
        req_a[i*8 +: 8]   = a;
        req_b[i*8 +: 8]   = b;
        req_op[i*4 +: 4]  = op;
    endtask

    // One clock cycle: predict, sample at negedge, compare, advance the model.
    task automatic step();
        int                 g;
        bit                 exp_to;
        logic [NUM_REQ-1:0] exp_ready;
        logic [7:0]         ea, eb;
        logic [3:0]         eop;
        logic [11:0]        res;
        g      = -1;
        exp_to = 1'b0;
        if (m_locked) begin
            if (req_valid[m_owner]) g = m_owner;
            else if (TO_EN && m_idle == int'(LOCK_MAX)) exp_to = 1'b1;
        end else begin
            for (int k = 1; k <= int'(NUM_REQ); k++) begin
                int j;
                j = (m_ptr + k) % int'(NUM_REQ);
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        exp_ready = '0;
        ea        = 8'h00;
        eb        = 8'h00;
        eop       = OP_PASS_B;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            ea  = req_a[g*8 +: 8];
            eb  = req_b[g*8 +: 8];
            eop = req_op[g*4 +: 4];
        end

        @(negedge clk);
        if (!rst) begin
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("alu_op", 32'(alu_op), 32'(eop));
            chk("alu_a", 32'(alu_a), 32'(ea));
            chk("alu_b", 32'(alu_b), 32'(eb));
            chk("lock_timeout", 32'(lock_timeout), 32'(exp_to));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        chk("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
        chk("rsp_flags", 32'(rsp_flags), 32'(m_rsp_flags));
        last_ready = req_ready;
        last_op    = alu_op;
        last_to    = lock_timeout;
        last_g     = g;

        if (rst) begin
            model_reset();
        end else if (g >= 0) begin
            res              = alu_fn(ea, eb, eop, m_ccr);
            m_ccr            = res[11:8];
            m_rsp_valid      = '0;
            m_rsp_valid[g]   = 1'b1;
            m_rsp_data       = res[7:0];
            m_rsp_flags      = res[11:8];
            m_idle           = 0;
            if (!m_locked) begin
                m_ptr = g;
                if (req_lock[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end
            end else if (!req_lock[g]) begin
                m_locked = 1'b0;
            end
        end else begin
            m_rsp_valid = '0;
            if (m_locked && TO_EN) begin
                if (exp_to) begin
                    m_locked = 1'b0;
                    m_ptr    = m_owner;
                end else begin
                    m_idle++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        // Reset
        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h0);
        chk("reset_rsp_flags", 32'(rsp_flags), 32'h0);
        chk("reset_lock_timeout", 32'(lock_timeout), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_alu_op", 32'(alu_op), 32'(OP_PASS_B));
        rst = 1'b0;

        // Contention straight after reset: grants alternate 0,1,0,1
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h01, OP_ADD);
        set_req(1, 1'b1, 1'b0, 8'h20, 8'h02, OP_SUB);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("contention_grant", 32'(last_ready), 32'(1 << (c % 2)));
            if (last_g >= 0) set_req(last_g, 1'b1, 1'b0, 8'(c * 7), 8'(c + 3), OP_XOR);
        end
        req_valid = '0;

        // Single request: 7F + 01
        set_req(0, 1'b1, 1'b0, 8'h7F, 8'h01, OP_ADD);
        step();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_data", 32'(rsp_data), 32'h80);
        chk("single_rsp_flags", 32'(rsp_flags), 32'b1010);
        req_valid = '0;
        step();

        // Lock chain on requester 1 while requester 0 waits
        set_req(0, 1'b1, 1'b0, 8'h03, 8'h04, OP_ADD);
        set_req(1, 1'b1, 1'b1, 8'h00, 8'h00, OP_SETC);
        step();
        chk("lock_setc_grant", 32'(last_ready), 32'b10);
        set_req(1, 1'b1, 1'b0, 8'h00, 8'h00, OP_RLC);
        step();
        chk("lock_rlc_grant", 32'(last_ready), 32'b10);
        chk("lock_rlc_data", 32'(rsp_data), 32'h01);
        req_valid[1] = 1'b0;
        step();
        chk("lock_release_grant", 32'(last_ready), 32'b01);
        req_valid = '0;

        // Idle cycles keep the carry from a borrowing SUB
        set_req(0, 1'b1, 1'b0, 8'h00, 8'h01, OP_SUB);
        step();
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("idle_alu_op", 32'(last_op), 32'(OP_PASS_B));
        end
        set_req(0, 1'b1, 1'b0, 8'h00, 8'h40, OP_PASS_B);
        step();
        chk("idle_hold_carry", 32'(rsp_flags[FLAG_C]), 32'h1);
        req_valid = '0;
        step();

        // Reset while locked with a response pending
        set_req(0, 1'b1, 1'b1, 8'h05, 8'h06, OP_ADD);
        step();
        req_valid = '0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        chk("reset_lock_rsp_valid", 32'(rsp_valid), 32'h0);
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h01, OP_ADD);
        set_req(1, 1'b1, 1'b0, 8'h02, 8'h02, OP_ADD);
        step();
        chk("reset_lock_grant", 32'(last_ready), 32'b01);
        req_valid = '0;
        step();

`ifdef ALU_ARB_LOCK_TIMEOUT_EN
        // Owner locks then goes silent: forced release after LOCK_MAX+1 cycles
        set_req(0, 1'b1, 1'b1, 8'h11, 8'h22, OP_ADD);
        step();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 8'h33, 8'h44, OP_ADD);
        k = 0;
        while (k < 40) begin
            step();
            k++;
            if (last_to === 1'b1) break;
        end
        chk("timeout_cycles", 32'(k), 32'(LOCK_MAX + 1));
        step();
        chk("timeout_next_grant", 32'(last_ready), 32'b10);
        req_valid = '0;
        step();
`else
        // Without the timeout a silent owner keeps the lock indefinitely
        set_req(0, 1'b1, 1'b1, 8'h11, 8'h22, OP_ADD);
        step();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 8'h33, 8'h44, OP_ADD);
        k = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (last_ready != '0) k++;
        end
        chk("lock_hold_no_grant", 32'(k), 32'h0);
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h02, OP_OR);
        step();
        req_valid[0] = 1'b0;
        step();
        chk("lock_hold_then_other", 32'(last_ready), 32'b10);
        req_valid = '0;
        step();
`endif

        // Random traffic; requests stay stable until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 55) begin
                    logic [3:0] op;
                    op = 4'($urandom_range(0, 10));
                    if (op == 4'd10) op = OP_PASS_A;
                    set_req(i, 1'b1, ($urandom_range(0, 99) < 25), 8'($urandom), 8'($urandom),
                            op);
                end
            end
            step();
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end
        req_valid = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU between NUM_REQ requesters (e.g. execute stage, LOOP/stack unit, debug port).
- Uses round-robin arbitration with a valid/ready request handshake and a registered response carrying the result and flags.
- Supports a lock: one requester keeps the ALU for back-to-back operations that depend on the ALU's condition-code register (RLC/RRC chains, SETC followed by RLC, and similar).
- Sits between the requesters and the ALU; it is the only driver of the ALU's A, B and opcode inputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- DATA_W, 8, operand/result width
- OP_W, 4, ALU opcode width
- LOCK_MAX, 15, maximum cycles a lock may be held (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*DATA_W  packed A operands, requester i at [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  packed B operands
- req_op  in  NUM_REQ*OP_W  packed opcodes
- req_lock  in  NUM_REQ  keep ownership after this operation
- alu_a  out  DATA_W  to ALU A
- alu_b  out  DATA_W  to ALU B
- alu_op  out  OP_W  to ALU opcode
- alu_out  in  DATA_W  ALU result
- alu_flags  in  4  ALU {V,C,N,Z}
- rsp_valid  out  NUM_REQ  one-cycle, one-hot response pulse
- rsp_data  out  DATA_W  registered result
- rsp_flags  out  4  registered {V,C,N,Z}
- lock_timeout  out  1  one-cycle pulse on forced unlock (optional feature only, else tied 0)

Behaviour:
- Reset (synchronous): req_ready=0, rsp_valid=0, rsp_data=0, rsp_flags=0, lock_timeout=0, state=S_FREE, rr_ptr=NUM_REQ-1, owner=0.
- States:
  - S_FREE: grant is the first requester with valid=1, searching from rr_ptr+1 upward with wrap.
  - S_LOCK: only the owner can be granted; all other req_ready=0 even when valid.
- Grant and accept:
  - Grant is combinational from registered state and pointer: req_ready[g]=req_valid[g].
  - Accept = valid & ready.
  - On accept, the granted operands/opcode drive alu_a/alu_b/alu_op in the same cycle.
- Idle drive: with no accept, alu_op=4'b0000 (pass B) and alu_a=alu_b=0, so the ALU's CCR keeps its flags. No other opcode is ever driven while idle.
- Response latency: accept at cycle T gives rsp_valid[g]=1 at T+1, with rsp_data/rsp_flags equal to alu_out/alu_flags sampled at the edge ending T. There is no response backpressure; the requester must take the pulse. rsp_data/rsp_flags hold their value between responses.
- Throughput: one operation per cycle, back-to-back allowed.
- Pointer: rr_ptr←g on every accept in S_FREE; unchanged in S_LOCK.
- Lock transitions:
  - S_FREE→S_LOCK when the accepted request has req_lock=1; owner←g.
  - S_LOCK→S_FREE on an accept from the owner with req_lock=0. That final operation is still executed and responded to.
  - In S_LOCK, owner valid=0 just waits and the lock is held.
- Simultaneous requests: the request nearest after rr_ptr wins; the others see ready=0 and must hold valid and operands stable.
- Reset mid-lock or mid-response: lock is dropped and the pending rsp_valid pulse is suppressed.
- NUM_REQ=1 is legal: always granted, lock has no effect.

Optional Feature:
- Macro: ALU_ARB_LOCK_TIMEOUT_EN.
- Defined:
  - A 4-bit hold counter clears on entering S_LOCK and on every owner accept, and increments each S_LOCK cycle without one.
  - When the counter reaches LOCK_MAX, the next edge forces S_FREE and pulses lock_timeout for one cycle.
  - rr_ptr←owner at that point, so the owner gets lowest priority next.
- Not defined: no counter, locks hold indefinitely, lock_timeout=0.

Decomposition:
- Package alu_arb_pkg:
  - ALU opcode localparams (OP_PASS_B=4'b0000, OP_ADD, OP_SUB, OP_RLC, OP_RRC, OP_SETC, OP_CLRC, …, OP_PASS_A=4'b1110)
  - Flag bit indices (Z=0, N=1, C=2, V=3)
  - State encoding (S_FREE, S_LOCK)
- Sub-module rr_pick: combinational round-robin picker that takes the request vector and pointer and returns a one-hot grant and its index. The top holds the FSM, response registers and optional counter.

Test Plan:
- Single request: req0 ADD A=8'h7F B=8'h01 → ready0 same cycle; next cycle rsp_valid=2'b01, rsp_data=8'h80, rsp_flags V=1,N=1,C=0,Z=0.
- Contention: both valid for 4 cycles after reset → grants alternate 0,1,0,1 with rsp_valid following one cycle later.
- Lock chain: req1 SETC lock=1, then RLC B=8'h00 lock=0, with req0 valid throughout → req0 stalled for 2 cycles; RLC gives rsp_data=8'h01; req0 granted on the third cycle.
- Idle flag hold: after SUB 8'h00−8'h01 (C=1), hold 5 idle cycles → alu_op=0000 throughout; a following pass-B op reports C=1.
- Reset in S_LOCK with a response pending → next cycle rsp_valid=0, req0 granted immediately.
- With ALU_ARB_LOCK_TIMEOUT_EN: owner locks then goes silent → lock_timeout pulses LOCK_MAX+1 cycles after the last owner accept; the other requester is granted next cycle.
